// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter: FSM encoding,
// grant identifiers, RAM control levels and byte-enable constants.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RMW  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;

  localparam int                  BE_WIDTH = 4;
  localparam logic [BE_WIDTH-1:0] BE_FULL  = 4'hF;
  localparam logic [BE_WIDTH-1:0] BE_NONE  = 4'h0;

endpackage

// File: rtl/ram_be_merge.sv
// Byte-lane merge for partial stores: each lane takes the new word where its
// enable is set and keeps the old RAM word otherwise.
module ram_be_merge
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] merged_word
);

  localparam int LANE = DATA_WIDTH / BE_WIDTH;

  for (genvar k = 0; k < BE_WIDTH; k++) begin : g_lane
    assign merged_word[k*LANE +: LANE] = be[k] ? new_word[k*LANE +: LANE]
                                               : old_word[k*LANE +: LANE];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one synchronous
// single-port RAM, with round-robin on collisions and read-modify-write stores.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [BE_WIDTH-1:0]   d_be_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  state_t                state, state_nxt;
  grant_t                last_grant;
  logic                  any_req, pick_d;
  logic [ADDR_WIDTH-1:0] if_addr_al, d_addr_al, addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, merged_word;
  logic [BE_WIDTH-1:0]   be_q;

  assign any_req    = if_req_i | d_req_i;
  // On collision the port that did not win last time gets the RAM.
  assign pick_d     = d_req_i & (~if_req_i | (last_grant == GRANT_IF));
  assign if_addr_al = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign d_addr_al  = {d_addr_i[ADDR_WIDTH-1:2], 2'b00};

  // last_grant doubles as the owner of the access in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_IF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (state == ST_IDLE && any_req) last_grant <= pick_d ? GRANT_D : GRANT_IF;
    end
  end

  // NOTE: store operands are pure datapath, qualified by the FSM, so they carry
  // no reset; latching them lets the requester drop its request mid-access.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && pick_d) begin
      addr_q  <= d_addr_al;
      wdata_q <= d_wdata_i;
      be_q    <= d_be_i;
    end
  end

  ram_be_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word    (ram_rdata_i),
    .new_word    (wdata_q),
    .be          (be_q),
    .merged_word (merged_word)
  );

  always_comb begin
    // NOTE: a default on every path keeps combinational processes latch-free.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          if (!pick_d || !d_we_i)                          state_nxt = ST_RD;
          else if (d_be_i == BE_FULL || d_be_i == BE_NONE) state_nxt = ST_ACK;
          else                                             state_nxt = ST_RMW;
        end
      end
      ST_RD:   state_nxt = ST_IDLE;
      ST_RMW:  state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_ce_o    = CHIP_DISABLE;
    ram_we_o    = WRITE_DISABLE;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if_ack_o    = 1'b0;
    if_rdata_o  = '0;
    d_ack_o     = 1'b0;
    d_rdata_o   = '0;
    if (rst_i) begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            if (!pick_d) begin
              ram_ce_o   = CHIP_ENABLE;
              ram_addr_o = if_addr_al;
            end else if (!(d_we_i && d_be_i == BE_NONE)) begin
              // Partial stores start with a plain read of the old word.
              ram_ce_o   = CHIP_ENABLE;
              ram_addr_o = d_addr_al;
              if (d_we_i && d_be_i == BE_FULL) begin
                ram_we_o    = WRITE_ENABLE;
                ram_wdata_o = d_wdata_i;
              end
            end
          end
        end
        ST_RD: begin
          if (last_grant == GRANT_D) begin
            d_ack_o   = 1'b1;
            d_rdata_o = ram_rdata_i;
          end else begin
            if_ack_o   = 1'b1;
            if_rdata_o = ram_rdata_i;
          end
        end
        ST_RMW: begin
          ram_ce_o    = CHIP_ENABLE;
          ram_we_o    = WRITE_ENABLE;
          ram_addr_o  = addr_q;
          ram_wdata_o = merged_word;
        end
        ST_ACK:  d_ack_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural synchronous RAM plus
// hand-computed expectations for fetch, load, store and reset scenarios.
module tb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, d_req_i, d_we_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        if_ack_o, d_ack_o, ram_ce_o, ram_we_o;
  logic [31:0] if_rdata_o, d_rdata_o, ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic        poke;
  logic [31:0] poke_addr, poke_data;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_be_i      (d_be_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .ram_ce_o    (ram_ce_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // Synchronous single-port RAM with a preload port for setup.
  always @(posedge clk_i) begin
    if (poke) mem[poke_addr[11:2]] <= poke_data;
    else if (ram_ce_o) begin
      if (ram_we_o) mem[ram_addr_o[11:2]] <= ram_wdata_o;
      else          ram_rdata_i <= mem[ram_addr_o[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs;
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_addr_i  = '0;
    d_wdata_i = '0;
    d_be_i    = '0;
  endtask

  task automatic poke_word(input logic [31:0] addr, input logic [31:0] data);
    poke      = 1'b1;
    poke_addr = addr;
    poke_data = data;
    tick();
    poke = 1'b0;
  endtask

  task automatic d_drive(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    d_req_i   = 1'b1;
    d_we_i    = we;
    d_addr_i  = addr;
    d_wdata_i = wdata;
    d_be_i    = be;
  endtask

  initial begin
    logic exp_d;
    poke = 1'b0; poke_addr = '0; poke_data = '0;
    // Reset with every request asserted: outputs must still be zero.
    rst_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    d_drive(1'b1, 32'h200, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk_i); #1;
    check("rst_ce",    {31'd0, ram_ce_o}, 32'd0);
    check("rst_we",    {31'd0, ram_we_o}, 32'd0);
    check("rst_addr",  ram_addr_o, 32'd0);
    check("rst_wdata", ram_wdata_o, 32'd0);
    check("rst_acks",  {30'd0, if_ack_o, d_ack_o}, 32'd0);
    idle_inputs();
    poke_word(32'h104, 32'h0000_0013);
    poke_word(32'h200, 32'h1122_3344);
    poke_word(32'h300, 32'hAABB_CCDD);

    // Single fetch.
    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    #1;
    check("fetch_ce",   {31'd0, ram_ce_o}, 32'd1);
    check("fetch_we",   {31'd0, ram_we_o}, 32'd0);
    check("fetch_addr", ram_addr_o, 32'h104);
    check("fetch_early_ack", {31'd0, if_ack_o}, 32'd0);
    tick(); #1;
    check("fetch_ack",   {31'd0, if_ack_o}, 32'd1);
    check("fetch_rdata", if_rdata_o, 32'h0000_0013);
    check("fetch_d_ack", {31'd0, d_ack_o}, 32'd0);
    check("fetch_rd_ce", {31'd0, ram_ce_o}, 32'd0);
    tick(); idle_inputs(); #1;
    check("idle_ce",    {31'd0, ram_ce_o}, 32'd0);
    check("idle_rdata", if_rdata_o, 32'd0);

    // Partial store (byte lane 1); request dropped during the write cycle.
    d_drive(1'b1, 32'h200, 32'h0000_AA00, 4'b0010);
    #1;
    check("sb_rd_ce",   {31'd0, ram_ce_o}, 32'd1);
    check("sb_rd_we",   {31'd0, ram_we_o}, 32'd0);
    check("sb_rd_addr", ram_addr_o, 32'h200);
    tick(); idle_inputs(); #1;
    check("sb_wr_ce",    {31'd0, ram_ce_o}, 32'd1);
    check("sb_wr_we",    {31'd0, ram_we_o}, 32'd1);
    check("sb_wr_addr",  ram_addr_o, 32'h200);
    check("sb_wr_wdata", ram_wdata_o, 32'h1122_AA44);
    check("sb_wr_ack",   {31'd0, d_ack_o}, 32'd0);
    tick(); #1;
    check("sb_ack",    {31'd0, d_ack_o}, 32'd1);
    check("sb_ack_ce", {31'd0, ram_ce_o}, 32'd0);
    check("sb_mem",    mem[32'h200 >> 2], 32'h1122_AA44);
    tick();

    // Full-word store to an unaligned address, then read it back.
    d_drive(1'b1, 32'h203, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("sw_ce",    {31'd0, ram_ce_o}, 32'd1);
    check("sw_we",    {31'd0, ram_we_o}, 32'd1);
    check("sw_addr",  ram_addr_o, 32'h200);
    check("sw_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    tick(); #1;
    check("sw_ack",    {31'd0, d_ack_o}, 32'd1);
    check("sw_ack_ce", {31'd0, ram_ce_o}, 32'd0);
    tick(); d_drive(1'b0, 32'h200, 32'd0, 4'hF); #1;
    check("lw_ce",   {31'd0, ram_ce_o}, 32'd1);
    check("lw_we",   {31'd0, ram_we_o}, 32'd0);
    tick(); #1;
    check("lw_ack",   {31'd0, d_ack_o}, 32'd1);
    check("lw_rdata", d_rdata_o, 32'hDEAD_BEEF);
    tick();

    // Store with no byte enables: no RAM access, ack next cycle.
    d_drive(1'b1, 32'h200, 32'h1234_5678, 4'h0);
    #1;
    check("be0_ce",  {31'd0, ram_ce_o}, 32'd0);
    check("be0_we",  {31'd0, ram_we_o}, 32'd0);
    check("be0_early_ack", {31'd0, d_ack_o}, 32'd0);
    tick(); #1;
    check("be0_ack", {31'd0, d_ack_o}, 32'd1);
    check("be0_mem", mem[32'h200 >> 2], 32'hDEAD_BEEF);
    tick(); idle_inputs();

    // Fresh reset, then both ports held: d first, then alternating.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    d_drive(1'b0, 32'h200, 32'd0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2 == 0);
      #1;
      check($sformatf("rr%0d_addr", i), ram_addr_o, exp_d ? 32'h200 : 32'h104);
      check($sformatf("rr%0d_ce", i), {31'd0, ram_ce_o}, 32'd1);
      tick(); #1;
      check($sformatf("rr%0d_acks", i), {30'd0, if_ack_o, d_ack_o},
            exp_d ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_rdata", i), exp_d ? d_rdata_o : if_rdata_o,
            exp_d ? 32'hDEAD_BEEF : 32'h0000_0013);
      tick();
    end
    idle_inputs();

    // Reset during the write half of a partial store.
    d_drive(1'b1, 32'h300, 32'h0000_00EE, 4'b0001);
    #1;
    check("rstrmw_rd_ce", {31'd0, ram_ce_o}, 32'd1);
    tick(); rst_i = 1'b0; #1;
    check("rstrmw_ce",    {31'd0, ram_ce_o}, 32'd0);
    check("rstrmw_we",    {31'd0, ram_we_o}, 32'd0);
    check("rstrmw_wdata", ram_wdata_o, 32'd0);
    check("rstrmw_ack",   {31'd0, d_ack_o}, 32'd0);
    tick();
    check("rstrmw_mem",   mem[32'h300 >> 2], 32'hAABB_CCDD);
    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    d_drive(1'b0, 32'h300, 32'd0, 4'hF);
    #1;
    check("post_rst_ce",   {31'd0, ram_ce_o}, 32'd1);
    check("post_rst_addr", ram_addr_o, 32'h300);
    tick(); #1;
    check("post_rst_acks",  {30'd0, if_ack_o, d_ack_o}, 32'd1);
    check("post_rst_rdata", d_rdata_o, 32'hAABB_CCDD);
    tick(); idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port if_req_i  input  1  instruction-fetch read request, held until if_ack_o.
REQ-006 SHALL have port if_addr_i  input  ADDR_WIDTH  fetch byte address.
REQ-007 SHALL have port if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port if_rdata_o  output  DATA_WIDTH  fetch word, valid only while if_ack_o=1, else 0.
REQ-009 SHALL have port d_req_i  input  1  data-port request, held until d_ack_o.
REQ-010 SHALL have port d_we_i  input  1  1=store, 0=load.
REQ-011 SHALL have port d_addr_i  input  ADDR_WIDTH  data byte address.
REQ-012 SHALL have port d_wdata_i  input  DATA_WIDTH  store data, already lane-aligned.
REQ-013 SHALL have port d_be_i  input  4  store byte enables, bit k = byte lane k.
REQ-014 SHALL have port d_ack_o  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port d_rdata_o  output  DATA_WIDTH  load word, valid only while d_ack_o=1, else 0.
REQ-016 SHALL have ports ram_ce_o, ram_we_o (outputs, 1), ram_addr_o (output, ADDR_WIDTH), ram_wdata_o (output, DATA_WIDTH), ram_rdata_i (input, DATA_WIDTH) to a synchronous single-port RAM: read data valid the cycle after ce=1/we=0; write commits at the edge ending a ce=1/we=1 cycle.

Function
REQ-017 SHALL implement FSM states IDLE, RD, RMW, ACK.
REQ-018 SHALL, in IDLE with a request pending, grant one requester, drive ram_ce_o=1 and ram_addr_o={addr[ADDR_WIDTH-1:2],2'b00} in the same cycle.
REQ-019 SHALL grant d when only d_req_i=1, IF when only if_req_i=1; on simultaneous requests SHALL grant the port not granted last (last_grant register, updated on every grant).
REQ-020 SHALL, for a load or fetch, go IDLE->RD; in RD SHALL pulse the grantee's ack and pass ram_rdata_i to its rdata port; next state IDLE.
REQ-021 SHALL, for a store with d_be_i=4'hF, drive ram_we_o=1 and ram_wdata_o=d_wdata_i in the IDLE grant cycle; IDLE->ACK; d_ack_o=1 in ACK.
REQ-022 SHALL, for a store with d_be_i not in {4'hF, 4'h0}, issue a read in IDLE, then in RMW drive ce=1, we=1, ram_wdata_o = per-lane (be ? d_wdata_i : ram_rdata_i); RMW->ACK.
REQ-023 SHALL, for a store with d_be_i=4'h0, issue no RAM access; IDLE->ACK with d_ack_o=1.
REQ-024 SHALL never accept a new request in RD, RMW or ACK; earliest next grant is the cycle after ack (throughput one access per 2 cycles; 3 for RMW).
REQ-025 SHALL complete an in-flight access and pulse ack even if the requester drops its request mid-access.
REQ-026 SHALL drive ram_ce_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0 whenever no access is issued that cycle.
REQ-027 SHALL never assert if_ack_o and d_ack_o in the same cycle.

Reset
REQ-028 SHALL, while rst_i=0, force all outputs to 0 combinationally and load state=IDLE, last_grant=IF at the clock edge.
REQ-029 SHALL abandon any in-flight access on reset, with no ack and no RAM write in the reset cycle.

Structure
REQ-030 SHALL take widths, state encodings, WRITE_ENABLE/DISABLE, CHIP_ENABLE/DISABLE, and ZERO from defines.v.
REQ-031 SHALL place the byte-lane merge in a combinational sub-module ram_be_merge (inputs old word, new word, be; output merged word).

Verification
REQ-032 Single fetch if_addr=0x104, RAM[0x104]=0x00000013 -> ram_ce at cycle N, if_ack=1 and if_rdata=0x00000013 at N+1.
REQ-033 Simultaneous if_req/d_req after reset, both held -> d granted first, IF second, alternating thereafter; acks never overlap.
REQ-034 SB-style store: RAM[0x200]=0x11223344, d_wdata=0x0000AA00, be=4'b0010 -> read at N, write 0x1122AA44 at N+1, d_ack at N+2.
REQ-035 Full store be=4'hF, d_wdata=0xDEADBEEF to 0x203 -> write to 0x200 at N, d_ack at N+1; subsequent load returns 0xDEADBEEF.
REQ-036 Store be=4'h0 -> no ram_ce, d_ack at N+1, RAM unchanged.
REQ-037 rst_i=0 asserted in RMW cycle -> no write commits, no ack, outputs 0, next grant after release goes to d.
